// File: rtl/start_delay_ctrl.sv
// start_delay_ctrl
// Round sequencer for the starting-line reaction game. Lets the external
// PRBS free-run between rounds, samples it on start to build a random
// hold-off delay, raises go when the delay runs out and measures the
// player's reaction time in whole milliseconds.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, PRBS running, waiting for start
// ARMED | lights on, hold-off delay counting down, stop = false start
// GO    | go asserted, reaction counter running, stop captures result
// DONE  | o_reactionMs valid, waiting for the next start
// FAULT | player pressed stop before go, waiting for the next start

module start_delay_ctrl #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int STEP_MS      = 16,
    parameter int MAX_REACT_MS = 9999
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [6:0]  i_randomValue,
    output logic        o_prbsEn,
    output logic        o_lightsOn,
    output logic        o_go,
    output logic [13:0] o_reactionMs,
    output logic        o_valid,
    output logic        o_falseStart,
    output logic        o_busy
);

    localparam int TICKS     = CLK_FREQ_HZ / 1000;
    localparam int PRE_W     = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int DLY_MAX   = MIN_DELAY_MS + 127 * STEP_MS;
    localparam int DLY_W_RAW = $clog2(DLY_MAX + 1);
    // Never narrower than the PRBS sample so the multiply sees every bit.
    localparam int DLY_W     = (DLY_W_RAW > 7) ? DLY_W_RAW : 7;
    localparam int REACT_W   = 14;

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICKS - 1);
    localparam logic [DLY_W-1:0]   DLY_ONE    = DLY_W'(1);
    localparam logic [DLY_W-1:0]   DLY_MIN    = DLY_W'(MIN_DELAY_MS);
    localparam logic [DLY_W-1:0]   DLY_STEP   = DLY_W'(STEP_MS);
    localparam logic [REACT_W-1:0] REACT_MAX  = REACT_W'(MAX_REACT_MS);
    localparam logic [REACT_W-1:0] REACT_LAST = REACT_W'(MAX_REACT_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_GO    = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PRE_W-1:0]    pre_cnt;
    logic [DLY_W-1:0]    delay_cnt;
    logic [DLY_W-1:0]    delay_load;
    logic [REACT_W-1:0]  react_cnt;
    logic [REACT_W-1:0]  reaction_ms;
    logic                in_round;
    logic                waiting;
    logic                ms_tick;
    logic                dly_last;
    logic                react_last;
    logic                state_change;

    assign in_round     = (state == S_ARMED) || (state == S_GO);
    assign waiting      = (state == S_IDLE) || (state == S_DONE) || (state == S_FAULT);
    assign ms_tick      = in_round && (pre_cnt == PRE_LAST);
    // A zero delay (only possible with MIN_DELAY_MS = 0) is treated like 1 ms
    // instead of wrapping the counter.
    assign dly_last     = (delay_cnt <= DLY_ONE);
    assign react_last   = (react_cnt >= REACT_LAST);
    assign state_change = (state_nxt != state);

    // Full-width hold-off delay; DLY_W is sized for rand = 127 so nothing is lost.
    assign delay_load = DLY_MIN + (DLY_W'(i_randomValue) * DLY_STEP);

    // State register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; stop outranks expiry/timeout, start outranks stop when waiting.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (i_start) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (i_stop) begin
                    state_nxt = S_FAULT;
                end else if (ms_tick && dly_last) begin
                    state_nxt = S_GO;
                end
            end
            S_GO: begin
                if (i_stop) begin
                    state_nxt = S_DONE;
                end else if (ms_tick && react_last) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        o_prbsEn     = 1'b1;
        o_lightsOn   = 1'b0;
        o_go         = 1'b0;
        o_valid      = 1'b0;
        o_falseStart = 1'b0;
        o_busy       = 1'b0;
        case (state)
            S_ARMED: begin
                o_prbsEn   = 1'b0;
                o_lightsOn = 1'b1;
                o_busy     = 1'b1;
            end
            S_GO: begin
                o_prbsEn = 1'b0;
                o_go     = 1'b1;
                o_busy   = 1'b1;
            end
            S_DONE: begin
                o_valid = 1'b1;
            end
            S_FAULT: begin
                o_falseStart = 1'b1;
            end
            default: begin
                o_prbsEn = 1'b1;
            end
        endcase
    end

    // Millisecond prescaler; restarts from 0 on every state entry.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pre_cnt <= '0;
        end else if (state_change || !in_round || ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Hold-off down-counter: loaded on start, one decrement per ms while armed.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            delay_cnt <= '0;
        end else if (waiting && i_start) begin
            delay_cnt <= delay_load;
        end else if ((state == S_ARMED) && ms_tick) begin
            delay_cnt <= delay_cnt - DLY_ONE;
        end
    end

    // Reaction counter: held at 0 while armed so GO always starts from zero.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            react_cnt <= '0;
        end else if (state == S_ARMED) begin
            react_cnt <= '0;
        end else if ((state == S_GO) && ms_tick && !react_last) begin
            react_cnt <= react_cnt + REACT_W'(1);
        end
    end

    // Result register: written only when a GO phase ends, otherwise keeps the last result.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            reaction_ms <= '0;
        end else if (state == S_GO) begin
            if (i_stop) begin
                reaction_ms <= react_cnt;
            end else if (ms_tick && react_last) begin
                reaction_ms <= REACT_MAX;
            end
        end
    end

    assign o_reactionMs = reaction_ms;

endmodule

// File: tb/tb_start_delay_ctrl.sv
// Bench for start_delay_ctrl with TICKS=4, MIN_DELAY_MS=10, STEP_MS=2,
// MAX_REACT_MS=50. Round outcomes go through a scoreboard queue that a
// monitor drains whenever o_valid or o_falseStart rises.

module tb_start_delay_ctrl;

    localparam int TICKS = 4;
    localparam int M_STOP    = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_FALSE   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [6:0]  rnd = '0;
    logic        prbs_en;
    logic        lights_on;
    logic        go;
    logic [13:0] reaction_ms;
    logic        valid;
    logic        false_start;
    logic        busy;

    start_delay_ctrl #(
        .CLK_FREQ_HZ  (4000),
        .MIN_DELAY_MS (10),
        .STEP_MS      (2),
        .MAX_REACT_MS (50)
    ) dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_start       (start),
        .i_stop        (stop),
        .i_randomValue (rnd),
        .o_prbsEn      (prbs_en),
        .o_lightsOn    (lights_on),
        .o_go          (go),
        .o_reactionMs  (reaction_ms),
        .o_valid       (valid),
        .o_falseStart  (false_start),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [6:0] rnd;
        int         mode;
        int         n;
        int         exp_go;
        int         exp_ms;
    } vec_t;

    typedef struct {
        bit fault;
        int ms;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sb(input bit fault, input int ms);
        sb_t e;
        e.fault = fault;
        e.ms    = ms;
        sb.push_back(e);
    endtask

    task automatic start_round(input logic [6:0] r, input string tag);
        rnd   = r;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " lights"}, 32'(lights_on), 1);
        check({tag, " prbsEn"}, 32'(prbs_en), 0);
        check({tag, " busy"}, 32'(busy), 1);
    endtask

    task automatic wait_go(input string tag, input int exp);
        int cyc;
        cyc = 0;
        while (!go && cyc < 3000) begin
            step();
            cyc++;
        end
        check({tag, " go_delay"}, 32'(cyc), 32'(exp));
    endtask

    task automatic stop_after(input int n);
        repeat (n - 1) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Scoreboard drain on result edges.
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && ((valid && !prev_v) || (false_start && !prev_f))) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: result with empty queue, ms %0d", reaction_ms);
            end else begin
                e = sb.pop_front();
                check("sb kind", 32'(false_start), 32'(e.fault));
                check("sb ms", 32'(reaction_ms), 32'(e.ms));
            end
        end
        prev_v = valid;
        prev_f = false_start;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit go_seen;
        int cyc;
        string tag;

        //            rnd    mode       n    go    ms
        vecs[0] = '{7'd5,   M_STOP,    30,  80,   7};
        vecs[1] = '{7'd0,   M_FALSE,   12,  0,    7};
        vecs[2] = '{7'd0,   M_FALSE,   40,  0,    7};
        vecs[3] = '{7'd3,   M_STOP,    1,   64,   0};
        vecs[4] = '{7'd1,   M_TIMEOUT, 200, 48,   50};
        vecs[5] = '{7'd127, M_STOP,    45,  1056, 11};
        vecs[6] = '{7'd10,  M_STOP,    199, 120,  49};
        vecs[7] = '{7'd64,  M_STOP,    5,   552,  1};

        // Reset values
        #2;
        check("rst prbsEn", 32'(prbs_en), 1);
        check("rst lights", 32'(lights_on), 0);
        check("rst go", 32'(go), 0);
        check("rst valid", 32'(valid), 0);
        check("rst falseStart", 32'(false_start), 0);
        check("rst busy", 32'(busy), 0);
        check("rst ms", 32'(reaction_ms), 0);
        #20;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("row%0d", i);
            start_round(vecs[i].rnd, tag);
            if (vecs[i].mode == M_FALSE) begin
                push_sb(1'b1, vecs[i].exp_ms);
                go_seen = 1'b0;
                repeat (vecs[i].n - 1) begin
                    step();
                    go_seen = go_seen | go;
                end
                stop = 1'b1;
                step();
                stop = 1'b0;
                check({tag, " go_seen"}, 32'(go_seen), 0);
                check({tag, " falseStart"}, 32'(false_start), 1);
                check({tag, " lights"}, 32'(lights_on), 0);
                check({tag, " go"}, 32'(go), 0);
                stop_after(3);
                check({tag, " fault_hold"}, 32'(false_start), 1);
            end else begin
                wait_go(tag, vecs[i].exp_go);
                push_sb(1'b0, vecs[i].exp_ms);
                if (vecs[i].mode == M_STOP) begin
                    stop_after(vecs[i].n);
                end else begin
                    cyc = 0;
                    while (!valid && cyc < 1000) begin
                        step();
                        cyc++;
                    end
                    check({tag, " timeout_cycles"}, 32'(cyc), 32'(vecs[i].n));
                end
                check({tag, " valid"}, 32'(valid), 1);
                check({tag, " go_off"}, 32'(go), 0);
                check({tag, " prbsEn"}, 32'(prbs_en), 1);
            end
            step();
        end

        // Reset mid-ARMED: outputs drop without waiting for a clock edge
        start_round(7'd5, "rstmid");
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid lights", 32'(lights_on), 0);
        check("rstmid go", 32'(go), 0);
        check("rstmid busy", 32'(busy), 0);
        check("rstmid prbsEn", 32'(prbs_en), 1);
        check("rstmid ms", 32'(reaction_ms), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Same-cycle start+stop in IDLE: start wins
        rnd   = 7'd9;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop lights", 32'(lights_on), 1);
        push_sb(1'b1, 0);
        stop_after(5);
        check("startstop falseStart", 32'(false_start), 1);

        // Start pulse during GO is ignored
        start_round(7'd0, "goign");
        wait_go("goign", 40);
        push_sb(1'b0, 4);
        repeat (9) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("goign go", 32'(go), 1);
        check("goign lights", 32'(lights_on), 0);
        stop_after(10);
        check("goign valid", 32'(valid), 1);

        repeat (3) step();
        check("sb drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
